// File: rtl/drone_cmd_sender.sv
// Frames a command ID plus argument, streams it over a valid/ready byte link,
// waits for a matching ack with timeout/retry, and reports a packed status word.
module drone_cmd_sender #(
  parameter int          ARG_BYTES      = 4,
  parameter int          DATA_W         = 32,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          MAX_RETRIES    = 3,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             cmd_id,
  input  logic [8*ARG_BYTES-1:0] cmd_arg,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      result,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   ack_valid,
  input  logic [7:0]             ack_id,
  input  logic [7:0]             ack_status
);
  localparam int NB = ARG_BYTES + 3;
  localparam int IW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE_STATE} state_t;

  state_t                 state, state_nx;
  logic [7:0]             id_q;
  logic [8*ARG_BYTES-1:0] arg_q;
  logic [IW-1:0]          idx;
  logic [TW-1:0]          tcnt;
  logic [8:0]             attempts;
  logic [7:0]             csum, frame_byte, att_sat;
  logic                   xfer, last_byte, ack_hit, expire, retry_ok;
  logic [DATA_W-1:0]      ack_word, to_word;

  // Frame byte selected from latched command; checksum recomputed from latched fields.
  always_comb begin
    csum = id_q;
    for (int i = 0; i < ARG_BYTES; i++) csum = csum ^ arg_q[8*i +: 8];
    frame_byte = csum;
    if (idx == '0) frame_byte = SYNC_BYTE;
    else if (idx == IW'(1)) frame_byte = id_q;
    else
      for (int i = 0; i < ARG_BYTES; i++)
        if (int'(idx) == i + 2) frame_byte = arg_q[8*(ARG_BYTES-1-i) +: 8];
  end

  assign tx_valid  = (state == SEND);
  assign tx_data   = tx_valid ? frame_byte : 8'h00;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE_STATE);
  assign xfer      = tx_valid && tx_ready;
  assign last_byte = (idx == IW'(NB-1));
  assign ack_hit   = ack_valid && (ack_id == id_q);
  assign expire    = (tcnt == TW'(TIMEOUT_CYCLES-1));
  assign retry_ok  = (attempts <= 9'(MAX_RETRIES));
  assign att_sat   = attempts[8] ? 8'hFF : attempts[7:0];

  always_comb begin
    ack_word        = '0;
    ack_word[23:0]  = {att_sat, ack_status, (ack_status == 8'h00) ? 8'd0 : 8'd1};
    to_word         = '0;
    to_word[23:0]   = {att_sat, 8'h00, 8'd2};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start) state_nx = SEND;
      SEND:       if (xfer && last_byte) state_nx = WAIT_ACK;
      WAIT_ACK:   if (ack_hit) state_nx = DONE_STATE;
                  else if (expire) state_nx = retry_ok ? SEND : DONE_STATE;
      DONE_STATE: state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      arg_q    <= '0;
      idx      <= '0;
      tcnt     <= '0;
      attempts <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          id_q     <= cmd_id;
          arg_q    <= cmd_arg;
          attempts <= 9'd1;
          result   <= '0;
          idx      <= '0;
        end
        SEND: if (xfer) begin
          idx <= last_byte ? '0 : idx + 1'b1;
          if (last_byte) tcnt <= '0;
        end
        WAIT_ACK: begin
          tcnt <= tcnt + 1'b1;
          // A matching ack on the expiry cycle takes priority over the timeout.
          if (ack_hit)       result   <= ack_word;
          else if (expire) begin
            if (retry_ok)    attempts <= attempts + 1'b1;
            else             result   <= to_word;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_drone_cmd_sender.sv
// Scoreboarded bench: driver pushes expected frame bytes and status words,
// a negedge monitor pops and compares them as the link and done fire.
module tb_drone_cmd_sender;
  localparam int AB = 4, DW = 32, TO = 16, MR = 2, NB = AB + 3;

  logic          clk = 0, rst_n = 0, start = 0;
  logic [7:0]    cmd_id = 0;
  logic [8*AB-1:0] cmd_arg = '0;
  logic          busy, done, tx_valid;
  logic [DW-1:0] result;
  logic [7:0]    tx_data;
  logic          tx_ready = 0, ack_valid = 0;
  logic [7:0]    ack_id = 0, ack_status = 0;

  drone_cmd_sender #(.ARG_BYTES(AB), .DATA_W(DW), .TIMEOUT_CYCLES(TO),
                     .MAX_RETRIES(MR), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_id(cmd_id), .cmd_arg(cmd_arg),
    .busy(busy), .done(done), .result(result), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .ack_valid(ack_valid),
    .ack_id(ack_id), .ack_status(ack_status));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0]    exp_bytes[$];
  logic [DW-1:0] exp_res[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: consumes expected traffic whenever the DUT presents it.
  logic       pstall = 0;
  logic [7:0] pdata = 0;
  always @(negedge clk) begin
    if (!rst_n) pstall <= 1'b0;
    else begin
      if (pstall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, pdata});
      if (tx_valid && tx_ready) begin
        if (exp_bytes.size() == 0) chk("tx_unexpected", {tx_valid, tx_data}, 9'h0);
        else chk("tx_byte", tx_data, exp_bytes.pop_front());
      end
      if (done) begin
        if (exp_res.size() == 0) chk("done_unexpected", done, 0);
        else chk("result", result, exp_res.pop_front());
      end
      pstall <= tx_valid && !tx_ready;
      pdata  <= tx_data;
    end
  end

  function automatic void push_frame(input logic [7:0] id, input logic [8*AB-1:0] arg, input int nbytes);
    logic [7:0] fr[$];
    logic [7:0] cs;
    fr = {8'hA5, id};
    cs = id;
    for (int i = AB - 1; i >= 0; i--) begin
      fr.push_back(arg[8*i +: 8]);
      cs = cs ^ arg[8*i +: 8];
    end
    fr.push_back(cs);
    for (int i = 0; i < nbytes; i++) exp_bytes.push_back(fr[i]);
  endfunction

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 500) begin @(posedge clk); #1; g++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  // ack_att: attempt carrying the ack (0 = never acked); mode: 0 ready, 1 alternating, 2 random.
  task automatic run_cmd(input logic [7:0] id, input logic [8*AB-1:0] arg, input int ack_att,
                         input int ack_off, input logic [7:0] st, input int mode, input bit noise);
    int nfr, cnt, g;
    bit werr, hit, tog;
    logic [DW-1:0] r;
    nfr = (ack_att == 0) ? MR + 1 : ack_att;
    for (int f = 0; f < nfr; f++) push_frame(id, arg, NB);
    r = '0;
    if (ack_att == 0) r[23:0] = {8'(MR + 1), 8'h00, 8'h02};
    else r[23:0] = {8'(ack_att), st, (st == 0) ? 8'h00 : 8'h01};
    exp_res.push_back(r);
    wait_idle();
    start = 1; cmd_id = id; cmd_arg = arg;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    tog = 1;
    for (int a = 1; a <= nfr; a++) begin
      cnt = 0; g = 0;
      while (cnt < NB && g < 200) begin
        case (mode)
          0: tx_ready = 1;
          1: begin tx_ready = tog; tog = ~tog; end
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        ack_valid = noise && ($urandom_range(0, 3) == 0);
        ack_id = id; ack_status = 8'h00;
        if (noise && $urandom_range(0, 7) == 0) begin
          start = 1; cmd_id = ~id; cmd_arg = ~arg;
        end else start = 0;
        if (tx_valid && tx_ready) cnt++;
        @(posedge clk); #1; g++;
      end
      start = 0; ack_valid = 0;
      if (cnt < NB) begin chk("frame_stuck", cnt, NB); return; end
      if (mode == 0) chk("no_bubble", g, NB);
      werr = 0; hit = 0;
      for (int off = 0; off < TO && !hit; off++) begin
        if (tx_valid || done) werr = 1;
        if (a == ack_att && off == ack_off) begin
          ack_valid = 1; ack_id = id; ack_status = st; hit = 1;
        end else if (noise && $urandom_range(0, 2) == 0) begin
          ack_valid = 1; ack_id = id ^ 8'($urandom_range(1, 255)); ack_status = 8'($urandom);
        end else ack_valid = 0;
        @(posedge clk); #1;
      end
      ack_valid = 0;
      chk("wait_quiet", werr, 0);
      if (a == nfr) chk("done_timing", done, 1);
      else chk("retry_timing", {tx_valid, tx_data}, {1'b1, 8'hA5});
    end
    start = noise;
    @(posedge clk); #1;
    start = 0;
    chk("back_to_idle", {done, busy}, 2'b00);
  endtask

  task automatic reset_mid_frame(input logic [7:0] id, input logic [8*AB-1:0] arg);
    int cnt = 0;
    push_frame(id, arg, 3);
    wait_idle();
    start = 1; cmd_id = id; cmd_arg = arg; tx_ready = 1;
    @(posedge clk); #1;
    start = 0;
    while (cnt < 3) begin
      if (tx_valid && tx_ready) cnt++;
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1 chk("reset_mid", {busy, done, tx_valid, tx_data, result}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("reset_idle", {busy, done, tx_valid}, 3'b000);
    chk("reset_flushed", exp_bytes.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_tx", {tx_valid, tx_data}, 9'h0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    run_cmd(8'h01, 32'h0000_0064, 1, 3, 8'h00, 0, 0);       // plain ACK
    run_cmd(8'h01, 32'h0000_0064, 1, 3, 8'h07, 0, 0);       // NACK, no retry
    run_cmd(8'h01, 32'h0000_0064, 0, 0, 8'h00, 0, 0);       // full timeout
    run_cmd(8'h3C, 32'hDEAD_BEEF, 1, TO - 1, 8'h00, 1, 1);  // ack on expiry cycle, backpressure
    run_cmd(8'h5A, 32'h1234_5678, 3, TO - 1, 8'h00, 1, 1);  // ack on final attempt expiry
    reset_mid_frame(8'h22, 32'hCAFE_F00D);
    run_cmd(8'h22, 32'hCAFE_F00D, 2, 5, 8'h00, 2, 1);
    for (int n = 0; n < 20; n++)
      run_cmd(8'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, TO - 1),
              ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255)), 2, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bytes_drained", exp_bytes.size(), 0);
    chk("results_drained", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/drone_cmd_sender.md
Name: drone_cmd_sender

Overview:
- Parametrised successor to the single-purpose command senders (takeoff, land, etc.). One block frames any command ID plus argument and streams it byte-wise over a valid/ready link.
- Waits for a matching acknowledgement, retries on timeout, and reports a structured status word.
- Sits between flight-control sequencing logic and the UART/link serializer.

Parameters:
- ARG_BYTES, 4, argument length in bytes (1..8).
- DATA_W, 32, result width (>= 24; upper bits zero).
- TIMEOUT_CYCLES, 1000, cycles to wait in WAIT_ACK per attempt (>= 2).
- MAX_RETRIES, 3, extra attempts after the first (0..255).
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- cmd_id  in  8  command identifier, latched on accept
- cmd_arg  in  8*ARG_BYTES  argument, latched on accept
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  status word, valid from the done pulse until the next accept
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte
- ack_valid  in  1  acknowledgement strobe
- ack_id  in  8  acknowledged command ID
- ack_status  in  8  0 = accepted, nonzero = rejected

Behaviour:
- Reset (async, rst_n low), all outputs: state IDLE, busy 0, done 0, result 0, tx_valid 0, tx_data 0. Attempt and timeout counters cleared. Reset mid-frame or mid-wait aborts with no done pulse.
- Frame, 3+ARG_BYTES bytes, in order:
  - SYNC_BYTE
  - cmd_id
  - cmd_arg bytes, MSB first
  - checksum = XOR of cmd_id and all arg bytes
- FSM states: IDLE, SEND, WAIT_ACK, DONE_STATE.
- IDLE:
  - start=1 latches cmd_id/cmd_arg, sets attempts=1, clears result, goes to SEND.
  - tx_valid rises the next cycle carrying SYNC_BYTE.
- SEND:
  - A byte transfers when tx_valid && tx_ready.
  - tx_data/tx_valid hold stable while tx_ready=0.
  - After the checksum byte transfers, tx_valid drops the next cycle and the FSM enters WAIT_ACK with the timeout counter at 0.
  - No bubbles between bytes when tx_ready is held high.
- WAIT_ACK:
  - Counter increments each cycle.
  - ack_valid with ack_id == latched cmd_id completes the command:
    - code 0 if ack_status == 0;
    - code 1 otherwise, with no retry.
  - ack_valid with a mismatched ID is ignored.
  - If the counter reaches TIMEOUT_CYCLES-1 without a matching ack:
    - if attempts <= MAX_RETRIES: attempts++ and return to SEND, resending the full frame from SYNC;
    - otherwise complete with code 2.
  - A matching ack in the same cycle as expiry wins (ack, not timeout).
- Acks arriving in IDLE, SEND or DONE_STATE are ignored.
- DONE_STATE:
  - done=1 for exactly one cycle, then IDLE.
  - start during DONE_STATE is ignored.
- result layout:
  - [7:0] code (0 ACK, 1 NACK, 2 TIMEOUT);
  - [15:8] ack_status (0 on timeout);
  - [23:16] attempts used (saturates at 255);
  - [DATA_W-1:24] zero.
- Latency, ARG_BYTES=4, tx_ready=1, start accepted in cycle 0:
  - bytes transfer in cycles 1..7;
  - WAIT_ACK begins cycle 8;
  - an ack in cycle k gives done in cycle k+1.
- start while busy is ignored and does not disturb the latched command.

Test Plan:
- Frame/ACK: cmd_id=0x01, cmd_arg=0x00000064, tx_ready=1, matching ack status 0x00 three cycles into WAIT_ACK.
  -> tx bytes A5 01 00 00 00 64 65 in consecutive cycles; one-cycle done; result=0x00010000.
- NACK: same command, ack_status=0x07.
  -> single frame only; result=0x00010701; no retry.
- Timeout with retries: TIMEOUT_CYCLES=16, MAX_RETRIES=2, no ack.
  -> 3 identical frames, each followed by 16 wait cycles; result=0x00030002.
- Backpressure and filtering:
  - tx_ready alternating 1/0 -> tx_data stable while stalled; frame intact.
  - mismatched ack_id=0x02 during WAIT_ACK -> ignored.
  - matching ack on the final timeout cycle -> result code 0, attempts 1.
- Reset and stray start:
  - rst_n low after byte 3 -> tx_valid=0, busy=0, no done.
  - new start after release -> full frame restarts from A5.
  - start pulsed while busy -> no effect.
